mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  synchronous reset, active-low.
REQ-003 SHALL have ports: valid_M  in  1  MEM-stage instruction valid.
REQ-004 SHALL have ports: mem_op_M  in  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9-15 treated as NONE.
REQ-005 SHALL have ports: alu_result_M  in  32  effective byte address from ALU.
REQ-006 SHALL have ports: write_data_M  in  32  store data (rt).
REQ-007 SHALL have ports: overflow_M  in  1  ALU overflow flag carried from EX.
REQ-008 SHALL have ports: PC_M  in  32  PC of MEM-stage instruction.
REQ-009 SHALL have ports: dmem_req/dmem_we  out  1 each; dmem_addr/dmem_wdata  out  32 each; dmem_be  out  4; dmem_ack  in  1; dmem_rdata  in  32.
REQ-010 SHALL have ports: read_data_W  out  32; rd_valid_W  out  1; stall  out  1.
REQ-011 SHALL have ports: exc_ov, exc_adel, exc_ades  out  1 each; exc_pc  out  32.

Function
REQ-012 SHALL implement FSM IDLE/BUSY; all outputs except stall registered.
REQ-013 start = IDLE & valid_M & op≠NONE & !overflow_M & aligned; aligned = word ops addr[1:0]==0, half ops addr[0]==0, byte ops always.
REQ-014 On start: next edge -> BUSY, dmem_req=1, dmem_we=1 for stores, dmem_addr={addr[31:2],2'b00}.
REQ-015 Byte lanes little-endian: byte be=1<<addr[1:0]; half be=addr[1]?1100:0011; word be=1111.
REQ-016 dmem_wdata: SW as-is; SH low half replicated to both halves; SB low byte replicated to all four lanes.
REQ-017 dmem_req/we/addr/wdata/be SHALL hold stable in BUSY until the dmem_ack cycle; dmem_req drops at that edge, FSM -> IDLE.
REQ-018 stall SHALL be combinational: 1 when start in IDLE, or in BUSY while dmem_ack=0; 0 in the ack cycle.
REQ-019 Load ack edge: read_data_W = selected lane(s), sign-extended (LH, LB) or zero-extended (LHU, LBU); rd_valid_W pulses 1 cycle.
REQ-020 Store ack edge: rd_valid_W stays 0; read_data_W holds previous value.
REQ-021 Latency: accept cycle N, dmem_req in N+1; ack in N+k gives data in N+k+1; minimum k=1.
REQ-022 valid_M & overflow_M (any op): no memory request; exc_ov pulse next cycle; exc_pc=PC_M; overflow beats address error.
REQ-023 Misaligned load: exc_adel pulse, no request. Misaligned store: exc_ades pulse, no request. exc_pc=PC_M in both.
REQ-024 Exception cases SHALL NOT assert stall.
REQ-025 dmem_ack in IDLE SHALL be ignored.
REQ-026 mem_op_M/valid_M changes in BUSY SHALL be ignored; upstream holds during stall.
REQ-027 Back-to-back accesses: the cycle after an ack edge may start a new access.

Reset
REQ-028 rst_n low at an edge: FSM -> IDLE; dmem_req, dmem_we, dmem_be, rd_valid_W, exc_* -> 0; dmem_addr, dmem_wdata, read_data_W, exc_pc -> 0.
REQ-029 Reset mid-BUSY: dmem_req drops at the reset edge; a pending transaction is abandoned, with no rd_valid_W and no exception.
REQ-030 stall SHALL be 0 while rst_n is low.

Verification
REQ-031 LB, addr=0x1003, rdata=0x80FF_1234, ack 3 cycles after req: req held 3 cycles, be=1000, stall high through the wait cycles, then read_data_W=0xFFFFFF80 with a 1-cycle rd_valid_W.
REQ-032 SH, addr=0x2002, wdata=0x0000_BEEF, ack same cycle as req: be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, no rd_valid_W.
REQ-033 LW, addr=0x3001: exc_adel=1 and exc_pc=PC_M next cycle; dmem_req never asserted; stall=0.
REQ-034 SW with overflow_M=1 and addr=0x4002 (also misaligned): only exc_ov pulses; exc_ades=0; no request.
REQ-035 LW accepted, rst_n low during BUSY: dmem_req=0 after the reset edge; a later dmem_ack causes no rd_valid_W.
REQ-036 Two back-to-back LWs, each acked after 1 cycle: two rd_valid_W pulses carrying the correct data in order; no spurious request between them.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit with a one-outstanding-request data memory handshake.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_M,
  input  logic [3:0]  mem_op_M,
  input  logic [31:0] alu_result_M,
  input  logic [31:0] write_data_M,
  input  logic        overflow_M,
  input  logic [31:0] PC_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] read_data_W,
  output logic        rd_valid_W,
  output logic        stall,
  output logic        exc_ov,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] exc_pc
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_next;
  logic w_load, w_store, w_word, w_half, w_aligned, w_take, w_start, w_exc;
  logic [3:0] w_be, r_op;
  logic [1:0] r_lane;
  logic [7:0] w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_wdata, w_ld;
  always_comb begin
    w_load = mem_op_M >= 4'd1 && mem_op_M <= 4'd5;
    w_store = mem_op_M >= 4'd6 && mem_op_M <= 4'd8;
    w_word = mem_op_M == 4'd1 || mem_op_M == 4'd6;
    w_half = mem_op_M == 4'd2 || mem_op_M == 4'd3 || mem_op_M == 4'd7;
    w_aligned = w_word ? alu_result_M[1:0] == 2'b00 : w_half ? !alu_result_M[0] : 1'b1;
    w_take = r_state == IDLE && valid_M;
    w_start = w_take && (w_load || w_store) && !overflow_M && w_aligned;
    w_exc = w_take && (overflow_M || ((w_load || w_store) && !w_aligned));
    w_next = r_state == IDLE ? (w_start ? BUSY : IDLE) : (dmem_ack ? IDLE : BUSY);
    stall = rst_n && (r_state == IDLE ? w_start : !dmem_ack);
    w_be = w_word ? 4'b1111 : w_half ? (alu_result_M[1] ? 4'b1100 : 4'b0011) : 4'b0001 << alu_result_M[1:0];
    w_wdata = mem_op_M == 4'd8 ? {4{write_data_M[7:0]}} :
              mem_op_M == 4'd7 ? {2{write_data_M[15:0]}} : write_data_M;
    w_rbyte = dmem_rdata[{r_lane, 3'b000} +: 8];
    w_rhalf = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_ld = r_op == 4'd2 ? {{16{w_rhalf[15]}}, w_rhalf} :
           r_op == 4'd3 ? {16'h0, w_rhalf} :
           r_op == 4'd4 ? {{24{w_rbyte[7]}}, w_rbyte} :
           r_op == 4'd5 ? {24'h0, w_rbyte} : dmem_rdata;
  end
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  // Request fields hold after ack; only dmem_req drops, so the bus sees a clean single-cycle release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_be <= 4'h0;
      read_data_W <= 32'h0;
      rd_valid_W <= 1'b0;
      exc_ov <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      exc_pc <= 32'h0;
      r_op <= 4'h0;
      r_lane <= 2'b00;
    end else begin
      rd_valid_W <= 1'b0;
      exc_ov <= w_take && overflow_M;
      exc_adel <= w_take && !overflow_M && w_load && !w_aligned;
      exc_ades <= w_take && !overflow_M && w_store && !w_aligned;
      if (w_exc) exc_pc <= PC_M;
      if (w_start) begin
        dmem_req <= 1'b1;
        dmem_we <= w_store;
        dmem_addr <= {alu_result_M[31:2], 2'b00};
        dmem_wdata <= w_wdata;
        dmem_be <= w_be;
        r_op <= mem_op_M;
        r_lane <= alu_result_M[1:0];
      end else if (r_state == BUSY && dmem_ack) begin
        dmem_req <= 1'b0;
        if (r_op <= 4'd5) begin
          read_data_W <= w_ld;
          rd_valid_W <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access with a transaction-level reference model.
module tb_mem_access;
  logic clk = 0, rst_n = 0, valid_M = 0, overflow_M = 0, dmem_ack = 0;
  logic [3:0] mem_op_M = 0;
  logic [31:0] alu_result_M = 0, write_data_M = 0, PC_M = 0, dmem_rdata = 0;
  logic dmem_req, dmem_we, rd_valid_W, stall, exc_ov, exc_adel, exc_ades;
  logic [31:0] dmem_addr, dmem_wdata, read_data_W, exc_pc;
  logic [3:0] dmem_be;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .valid_M(valid_M), .mem_op_M(mem_op_M),
    .alu_result_M(alu_result_M), .write_data_M(write_data_M), .overflow_M(overflow_M),
    .PC_M(PC_M), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .read_data_W(read_data_W), .rd_valid_W(rd_valid_W), .stall(stall), .exc_ov(exc_ov),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_pc(exc_pc)
  );

  function automatic int f_sz(input logic [3:0] op);
    return (op == 1 || op == 6) ? 4 : (op == 2 || op == 3 || op == 7) ? 2 : 1;
  endfunction
  function automatic logic f_isld(input logic [3:0] op);
    return op >= 1 && op <= 5;
  endfunction
  function automatic logic f_isst(input logic [3:0] op);
    return op >= 6 && op <= 8;
  endfunction
  function automatic logic f_al(input logic [3:0] op, input logic [1:0] a);
    return (int'(a) % f_sz(op)) == 0;
  endfunction
  function automatic logic [3:0] f_be(input logic [3:0] op, input logic [1:0] a);
    logic [31:0] t;
    int sz;
    sz = f_sz(op);
    t = ((32'd1 << sz) - 32'd1) << ((int'(a) / sz) * sz);
    return t[3:0];
  endfunction
  function automatic logic [31:0] f_wd(input logic [3:0] op, input logic [31:0] wd);
    int sz;
    sz = f_sz(op);
    return sz == 4 ? wd : sz == 2 ? {16'h0, wd[15:0]} * 32'h00010001 : {24'h0, wd[7:0]} * 32'h01010101;
  endfunction
  function automatic logic [31:0] f_load(input logic [3:0] op, input logic [1:0] a, input logic [31:0] d);
    logic [63:0] v;
    int sz;
    sz = f_sz(op);
    v = {32'h0, d} >> (8 * int'(a));
    v = v & ((64'd1 << (8 * sz)) - 64'd1);
    if ((op == 2 || op == 4) && v[8 * sz - 1]) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  logic m_busy, m_req, m_we, m_rdv, m_ov, m_adel, m_ades;
  logic [31:0] m_addr, m_wdata, m_rd, m_pc;
  logic [3:0] m_be, m_op;
  logic [1:0] m_a;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 0; m_req <= 0; m_we <= 0; m_rdv <= 0; m_ov <= 0; m_adel <= 0; m_ades <= 0;
      m_addr <= 0; m_wdata <= 0; m_rd <= 0; m_pc <= 0; m_be <= 0; m_op <= 0; m_a <= 0;
    end else begin
      m_rdv <= 0; m_ov <= 0; m_adel <= 0; m_ades <= 0;
      if (m_busy) begin
        if (dmem_ack) begin
          m_busy <= 0;
          m_req <= 0;
          if (f_isld(m_op)) begin
            m_rd <= f_load(m_op, m_a, dmem_rdata);
            m_rdv <= 1;
          end
        end
      end else if (valid_M) begin
        if (overflow_M) begin
          m_ov <= 1;
          m_pc <= PC_M;
        end else if (f_isld(mem_op_M) || f_isst(mem_op_M)) begin
          if (!f_al(mem_op_M, alu_result_M[1:0])) begin
            m_adel <= f_isld(mem_op_M);
            m_ades <= f_isst(mem_op_M);
            m_pc <= PC_M;
          end else begin
            m_busy <= 1;
            m_req <= 1;
            m_we <= f_isst(mem_op_M);
            m_addr <= alu_result_M & ~32'h3;
            m_wdata <= f_wd(mem_op_M, write_data_M);
            m_be <= f_be(mem_op_M, alu_result_M[1:0]);
            m_op <= mem_op_M;
            m_a <= alu_result_M[1:0];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic e_stall;
    e_stall = !rst_n ? 1'b0 : m_busy ? !dmem_ack :
              (valid_M && (f_isld(mem_op_M) || f_isst(mem_op_M)) && !overflow_M && f_al(mem_op_M, alu_result_M[1:0]));
    chk("req", dmem_req, m_req);
    chk("we", dmem_we, m_we);
    chk("addr", dmem_addr, m_addr);
    chk("wdata", dmem_wdata, m_wdata);
    chk("be", dmem_be, m_be);
    chk("rdata", read_data_W, m_rd);
    chk("rdv", rd_valid_W, m_rdv);
    chk("ov", exc_ov, m_ov);
    chk("adel", exc_adel, m_adel);
    chk("ades", exc_ades, m_ades);
    chk("pc", exc_pc, m_pc);
    chk("stall", stall, e_stall);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] pc, input logic ov, input int k, input logic [31:0] rd);
    valid_M = 1; mem_op_M = op; alu_result_M = a; write_data_M = wd; PC_M = pc; overflow_M = ov; dmem_ack = 0;
    #1;
    if (k == 0) chk("stall_exc", stall, 0);
    else chk("stall_start", stall, 1);
    step();
    if (k == 0) begin
      valid_M = 0; overflow_M = 0;
    end
    for (int i = 1; i <= k; i++) begin
      dmem_ack = (i == k);
      dmem_rdata = (i == k) ? rd : 32'hDEADBEEF;
      if (i == k) begin
        valid_M = 0; mem_op_M = 0;
      end
      #1;
      if (i < k) chk("stall_wait", stall, 1);
      else chk("stall_ack", stall, 0);
      step();
    end
    dmem_ack = 0;
  endtask

  initial begin
    repeat (2) step();
    rst_n = 1;
    chk("rst_req", dmem_req, 0);
    chk("rst_rd", read_data_W, 0);
    chk("rst_pc", exc_pc, 0);
    acc(4'd4, 32'h1003, 32'h0, 32'h100, 0, 3, 32'h80FF1234);
    chk("lb_data", read_data_W, 32'hFFFFFF80);
    chk("lb_rdv", rd_valid_W, 1);
    chk("lb_be", dmem_be, 4'b1000);
    step();
    chk("lb_pulse", rd_valid_W, 0);
    acc(4'd7, 32'h2002, 32'h0000BEEF, 32'h104, 0, 1, 32'h0);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    chk("sh_we", dmem_we, 1);
    chk("sh_rdv", rd_valid_W, 0);
    chk("sh_hold", read_data_W, 32'hFFFFFF80);
    acc(4'd1, 32'h3001, 32'h0, 32'h108, 0, 0, 32'h0);
    chk("lw_adel", exc_adel, 1);
    chk("lw_pc", exc_pc, 32'h108);
    chk("lw_noreq", dmem_req, 0);
    acc(4'd6, 32'h4002, 32'h1234, 32'h10C, 1, 0, 32'h0);
    chk("sw_ov", exc_ov, 1);
    chk("sw_ades", exc_ades, 0);
    chk("sw_pc", exc_pc, 32'h10C);
    acc(4'd7, 32'h5001, 32'h55, 32'h110, 0, 0, 32'h0);
    chk("sh_ades", exc_ades, 1);
    acc(4'd0, 32'h0, 32'h0, 32'h114, 1, 0, 32'h0);
    chk("none_ov", exc_ov, 1);
    acc(4'd9, 32'h6000, 32'h0, 32'h118, 0, 0, 32'h0);
    dmem_ack = 1; dmem_rdata = 32'h77777777;
    step();
    dmem_ack = 0;
    chk("idle_ack_rdv", rd_valid_W, 0);
    acc(4'd3, 32'h6002, 32'h0, 32'h11C, 0, 2, 32'h89ABCDEF);
    chk("lhu", read_data_W, 32'h000089AB);
    acc(4'd2, 32'h6000, 32'h0, 32'h120, 0, 1, 32'h12348001);
    chk("lh", read_data_W, 32'hFFFF8001);
    acc(4'd5, 32'h6001, 32'h0, 32'h124, 0, 1, 32'h0000F500);
    chk("lbu", read_data_W, 32'h000000F5);
    acc(4'd8, 32'h7001, 32'h12345678, 32'h128, 0, 1, 32'h0);
    chk("sb_be", dmem_be, 4'b0010);
    chk("sb_wdata", dmem_wdata, 32'h78787878);
    acc(4'd6, 32'h7004, 32'hCAFEF00D, 32'h12C, 0, 2, 32'h0);
    chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);
    chk("sw_addr", dmem_addr, 32'h7004);
    acc(4'd1, 32'h8000, 32'h0, 32'h130, 0, 1, 32'h11111111);
    chk("b2b_1", read_data_W, 32'h11111111);
    chk("b2b_1v", rd_valid_W, 1);
    acc(4'd1, 32'h8004, 32'h0, 32'h134, 0, 1, 32'h22222222);
    chk("b2b_2", read_data_W, 32'h22222222);
    chk("b2b_2v", rd_valid_W, 1);
    valid_M = 1; mem_op_M = 4'd1; alu_result_M = 32'h9000; PC_M = 32'h138;
    step();
    valid_M = 0; mem_op_M = 0;
    chk("mid_req", dmem_req, 1);
    rst_n = 0;
    #1 chk("rst_stall", stall, 0);
    step();
    chk("rst_drop", dmem_req, 0);
    rst_n = 1; dmem_ack = 1; dmem_rdata = 32'h33333333;
    step();
    dmem_ack = 0;
    chk("rst_rdv", rd_valid_W, 0);
    chk("rst_data", read_data_W, 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
